// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounced press/release.
// Drives one active-low row per scan tick, reads active-low column returns,
// and reports each qualified press as a key code plus a one-cycle strobe.
module keypad_scan #(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    state_t          state;
    logic [3:0]      col_s1;
    logic [3:0]      col_s;
    logic [CW-1:0]   cnt;
    logic            tick;
    logic [1:0]      ridx;
    logic [1:0]      cidx;
    logic [1:0]      cidx_sel;
    logic [DW-1:0]   dcnt;
    logic [DW-1:0]   rcnt;

    // Two-flop synchronizer for the asynchronous column returns
    always_ff @(posedge clk) begin
        if (rst) begin
            col_s1 <= '1;
            col_s  <= '1;
        end else begin
            col_s1 <= col;
            col_s  <= col_s1;
        end
    end

    // Scan tick divider: one-cycle tick at the end of every CLK_DIV period
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == DIV_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == DIV_LAST);

    // Lowest-index low column wins when several are pressed on the same row
    always_comb begin
        cidx_sel = 2'd0;
        if (!col_s[0])      cidx_sel = 2'd0;
        else if (!col_s[1]) cidx_sel = 2'd1;
        else if (!col_s[2]) cidx_sel = 2'd2;
        else if (!col_s[3]) cidx_sel = 2'd3;
    end

    assign row = ~(4'b0001 << ridx);

    // Scan / debounce / held-key state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            ridx      <= 2'd0;
            cidx      <= 2'd0;
            dcnt      <= '0;
            rcnt      <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (col_s == 4'b1111) begin
                            ridx <= ridx + 2'd1;
                        end else begin
                            cidx <= cidx_sel;
                            dcnt <= DW'(1);
                            // A single-tick debounce accepts on the detecting tick
                            if (DEBOUNCE_TICKS == 1) begin
                                key_code  <= {ridx, cidx_sel};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rcnt      <= '0;
                                state     <= PRESSED;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!col_s[cidx]) begin
                            if (dcnt == DB_LAST) begin
                                key_code  <= {ridx, cidx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rcnt      <= '0;
                                state     <= PRESSED;
                            end else begin
                                dcnt <= dcnt + 1'b1;
                            end
                        end else begin
                            ridx  <= ridx + 2'd1;
                            state <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (col_s[cidx]) begin
                            if (rcnt == DB_LAST) begin
                                key_held <= 1'b0;
                                rcnt     <= '0;
                                ridx     <= ridx + 2'd1;
                                state    <= SCAN;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end else begin
                            rcnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad and reports debounced key presses to the clock's time-set and alarm-set logic.
- It is the input-side counterpart of the seven-segment scan driver. That driver time-multiplexes digit enables outward; this block time-multiplexes row drives outward and reads column returns inward.
- Each qualified press produces one key code plus a one-cycle valid strobe.

Parameters:
- CLK_DIV, 50000, system clocks per scan tick; must be >= 2.
- DEBOUNCE_TICKS, 4, consecutive agreeing scan ticks required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- col  input  4  keypad column returns; active-low, pulled up; asynchronous to clk.
- row  output  4  keypad row drives; active-low; exactly one bit is low at any time.
- key_code  output  4  last accepted key, equal to row_index*4 + col_index.
- key_valid  output  1  one-clk pulse when a new key is accepted.
- key_held  output  1  high from acceptance until the release is debounced.

Behaviour:
- Column synchronizer: two-flop synchronizer on col, reset value 4'b1111. All decisions use the second-stage value colS.
- Tick generator:
  - Counter runs 0..CLK_DIV-1 and wraps.
  - tick is high for one clk when the counter equals CLK_DIV-1.
  - Reset sets the counter to 0.
- Row driver:
  - Internal ridx is 2 bits; row = ~(4'b0001 << ridx).
  - Row advances only where stated below, always wrapping 3 -> 0.
  - The row only changes on a tick, so it has a full tick period to settle before the next sample.
- Column select: if several colS bits are low, the lowest-index low bit wins (cidx).
- SCAN state, on each tick:
  - colS == 4'b1111: ridx advances.
  - Otherwise: latch cidx, set dcnt = 1, go to DEBOUNCE; ridx holds.
- DEBOUNCE state, on each tick:
  - colS[cidx] still low: dcnt increments.
  - colS[cidx] high: go to SCAN and advance ridx. No output.
  - Accept when dcnt reaches DEBOUNCE_TICKS; with DEBOUNCE_TICKS = 1, the accept happens on the detecting tick itself.
- On accept:
  - In the next clk: key_code <= {ridx, cidx}, key_valid = 1 for exactly one clk, key_held <= 1.
  - Go to PRESSED with rcnt = 0.
- PRESSED state:
  - ridx holds. Other keys pressed meanwhile are ignored; there is no rollover.
  - On each tick, colS[cidx] high: rcnt increments; colS[cidx] low: rcnt resets to 0.
  - When rcnt reaches DEBOUNCE_TICKS: key_held <= 0, go to SCAN, advance ridx.
- Outputs:
  - key_code holds its value until the next accept.
  - key_valid is never asserted in two consecutive cycles.
  - Only one key is reported per press-release cycle.
- Reset, including mid-press:
  - state = SCAN, ridx = 0 (row = 4'b1110), key_code = 0, key_valid = 0, key_held = 0, all counters = 0, synchronizer = 4'b1111.
  - A key still held after reset is re-detected and re-reported as a fresh press.
- Latency: from colS going low while its row is driven to the key_valid pulse is (DEBOUNCE_TICKS-1) tick periods, plus the wait to the next tick, plus 1 clk.

Test Plan:
Bench parameters: CLK_DIV=4, DEBOUNCE_TICKS=3.
- Idle: rst 2 cycles, col=4'b1111 -> row cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clks; key_valid never high; key_held=0.
- Clean press of key 6 (row 1, col 2): model pulls col[2] low only while row=4'b1101, held 20 ticks -> exactly one key_valid pulse with key_code=4'd6, 2 ticks plus <=1 tick plus 1 clk after detection. key_held=1 until 3 ticks after release, then scanning resumes at row index 2.
- Bounce: col[0] on row 3 low for 1 tick, high 1 tick, repeated 5 times, then stable low -> no pulse during the bounce; one pulse with key_code=4'd12 after stable low.
- Two keys on the same row (row 0, col1 and col3 low) -> key_code=4'd1; releasing col3 only causes no new pulse and key_held stays 1; releasing col1 -> key_held drops after 3 ticks.
- Reset mid-press: assert rst during PRESSED with the key still down -> next clk row=4'b1110 and key_held=0; the key is then re-reported with one new key_valid.
- Release glitch: in PRESSED, col high 2 ticks, low 1 tick, high 3 ticks -> key_held falls only after the final 3 consecutive high ticks; no extra key_valid.
